operand_memory: RTL and testbench
=================================

Name: operand_memory

Overview:
- Parametrised, clocked successor to the fixed 16x16 operand ROM.
- Provides a writable operand store with a registered read port, 1-cycle read latency and a valid strobe.
- After every reset, a self-initialisation sequence loads the team's default operand table into the store.
- Sits between the operand-select logic and the ALU datapath; any operand slot (operand1/operand2) can instantiate it.

Parameters:
- DATA_W, 16: word width in bits.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- init_busy  output  1  high while reset is asserted and during the init sequence.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address.
- rd_valid  output  1  one-cycle pulse; rd_data is valid on this cycle.
- rd_data  output  DATA_W  registered read data; holds its value until the next accepted read.

Behaviour:
- Reset values: init_busy=1, rd_valid=0, rd_data=0, FSM=S_INIT, init counter=0. The array itself is not reset.
- FSM state S_INIT:
  - Each cycle, write mem[cnt] = init_word(cnt) and increment cnt.
  - When cnt == DEPTH-1, write that last word and go to S_RUN.
  - Init therefore takes exactly DEPTH cycles after rst deasserts.
  - init_busy drops on the first S_RUN cycle.
  - wr_en and rd_en are ignored in S_INIT; rd_valid stays 0.
- FSM state S_RUN:
  - Write: on wr_en, mem[wr_addr] <= wr_data.
  - Read: on rd_en, rd_data <= mem[rd_addr] and rd_valid <= 1 on the next cycle (latency 1).
  - With no rd_en, rd_valid <= 0 and rd_data holds.
  - Back-to-back reads are allowed every cycle (throughput 1 per cycle).
- Simultaneous read and write to the same address in one cycle: write-first; rd_data returns wr_data.
- Simultaneous read and write to different addresses: both proceed independently.
- Out-of-range address (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Writes are dropped.
  - Reads return 0 and still pulse rd_valid.
- Reset mid-operation (rst asserted in any state):
  - Outputs return to their reset values immediately (asynchronous).
  - Any pending rd_valid is killed.
  - Init restarts from address 0 after rst deasserts; previously written data is overwritten by the defaults.
- init_word(i): returns DEFAULT_TABLE[i][DATA_W-1:0] for i < 16, otherwise 0.
  - When DATA_W > 16, the table entry is zero-extended.

Optional Feature:
- Macro: OPERAND_MEMORY_RD2_EN.
- When defined, the block adds a second independent read port: rd2_en (input, 1), rd2_addr (input, ADDR_W), rd2_valid (output, 1), rd2_data (output, DATA_W).
  - Port 2 has identical latency, reset, init-blocking, out-of-range and write-first rules as port 1.
  - Both read ports may target the same address in the same cycle; each returns the same word.
- When not defined, those ports do not exist and the array has a single read port.

Decomposition:
- Package operand_memory_pkg holds:
  - DEFAULT_TABLE: 16 x 16-bit constants, entry 0 = 16'h4DA3, entry 5 = 16'hD635, entry 15 = 16'hD919, plus the remaining team operand constants.
  - function init_word.
  - FSM state typedef {S_INIT, S_RUN}.
- One sub-module: operand_memory_array.
  - Plain storage with one write port and N registered read ports (N = 1 or 2); no reset.
- The top level holds the FSM, init counter, address-range checks, bypass mux and valid flags.

Test Plan:
- Reset then release; count cycles to init_busy=0 -> exactly DEPTH cycles (16 at defaults); rd_valid=0 throughout init; read to addr 0, 5, 15 -> rd_data 16'h4DA3, 16'hD635, 16'hD919 one cycle later, rd_valid one-cycle pulse.
- Write 16'hBEEF to addr 3, then read addr 3 next cycle -> 16'hBEEF; read addr 4 -> unchanged default.
- Same-cycle wr_en and rd_en to addr 7 with wr_data 16'h1234 -> rd_data 16'h1234 next cycle (write-first).
- DEPTH=12 build: read addr 13 -> rd_data 0, rd_valid 1; write addr 13 followed by read addr 13 -> still 0; init takes 12 cycles.
- Assert rst mid-stream of back-to-back reads and after writing 16'hBEEF to addr 3 -> rd_valid/rd_data drop to 0 immediately; after re-init, addr 3 reads its default value again.
- With OPERAND_MEMORY_RD2_EN: rd_addr=2 and rd2_addr=2 in the same cycle -> both return the same default word one cycle later; rd2_valid/rd2_data blocked during init.

Source files
------------

// File: rtl/operand_memory_pkg.sv
// operand_memory_pkg: shared definitions for the operand memory.
//   NUM_RD        - number of read ports (2 when OPERAND_MEMORY_RD2_EN is defined, else 1)
//   state_t       - init/run FSM state
//   DEFAULT_TABLE - team default operand constants loaded after every reset
//   init_word()   - default word for an index (0 beyond the table)
package operand_memory_pkg;

`ifdef OPERAND_MEMORY_RD2_EN
  localparam int unsigned NUM_RD = 2;
`else
  localparam int unsigned NUM_RD = 1;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [15:0] DEFAULT_TABLE [16] = '{
    16'h4DA3, 16'h1F2C, 16'h83B7, 16'h5E01,
    16'h0A9D, 16'hD635, 16'h7C48, 16'h2B6E,
    16'h91F0, 16'h3D27, 16'hE4A2, 16'h6B59,
    16'hC08E, 16'h17D4, 16'hA36B, 16'hD919
  };

  function automatic logic [15:0] init_word(input logic [31:0] idx);
    if (idx < 32'd16) return DEFAULT_TABLE[idx[3:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/operand_memory_array.sv
// operand_memory_array: plain storage, one write port and NRD registered read ports.
// No reset; read registers hold when their enable is low.
//   clk   - clock
//   we    - write enable, waddr/wdata - write address/data
//   re    - per-port read enable, raddr - per-port read address
//   rdata - per-port registered read data (old contents on a same-cycle write)
module operand_memory_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NRD    = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [NRD-1:0]                 re,
  input  logic [NRD-1:0][ADDR_W-1:0]     raddr,
  output logic [NRD-1:0][DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NRD; i++) begin
      if (re[i]) rdata[i] <= mem[raddr[i]];
    end
  end

endmodule

// File: rtl/operand_memory.sv
// operand_memory: writable operand store with self-initialisation after reset.
// Optional second read port enabled by defining OPERAND_MEMORY_RD2_EN.
//   clk, rst           - clock, asynchronous active-high reset
//   init_busy          - high during reset and the DEPTH-cycle default-table load
//   wr_en/wr_addr/wr_data - write port (ignored during init, dropped if out of range)
//   rd_en/rd_addr      - read request; rd_valid/rd_data one cycle later
//   rd2_*              - second read port (only with OPERAND_MEMORY_RD2_EN)
module operand_memory
  import operand_memory_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
`ifdef OPERAND_MEMORY_RD2_EN
  ,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              rd2_valid,
  output logic [DATA_W-1:0] rd2_data
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t                          state_q;
  logic [ADDR_W-1:0]               cnt_q;
  logic                            run;
  logic                            wr_ok;
  logic                            mem_we;
  logic [ADDR_W-1:0]               mem_waddr;
  logic [DATA_W-1:0]               mem_wdata;
  logic [NUM_RD-1:0]               req;
  logic [NUM_RD-1:0]               in_range;
  logic [NUM_RD-1:0]               arr_re;
  logic [NUM_RD-1:0][ADDR_W-1:0]   raddr;
  logic [NUM_RD-1:0][DATA_W-1:0]   arr_data;
  logic [NUM_RD-1:0][DATA_W-1:0]   data;
  // Per-port output qualifiers: zero_q forces 0 (reset / out-of-range read),
  // byp_q selects the captured write data for a same-address write-first read.
  logic [NUM_RD-1:0]               valid_q;
  logic [NUM_RD-1:0]               zero_q;
  logic [NUM_RD-1:0]               byp_q;
  logic [NUM_RD-1:0][DATA_W-1:0]   byp_data_q;

  always_comb begin
    req[0]   = rd_en;
    raddr[0] = rd_addr;
`ifdef OPERAND_MEMORY_RD2_EN
    req[1]   = rd2_en;
    raddr[1] = rd2_addr;
`endif
  end

  assign run   = (state_q == S_RUN);
  assign wr_ok = run && wr_en && ({1'b0, wr_addr} < DEPTH_X);

  // Init owns the write port until the whole table is loaded.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = DATA_W'(init_word(32'(cnt_q)));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      in_range[i] = ({1'b0, raddr[i]} < DEPTH_X);
      arr_re[i]   = run && req[i] && in_range[i];
      if (zero_q[i])     data[i] = '0;
      else if (byp_q[i]) data[i] = byp_data_q[i];
      else               data[i] = arr_data[i];
    end
  end

  operand_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NRD    (NUM_RD)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (arr_re),
    .raddr (raddr),
    .rdata (arr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      init_busy  <= 1'b1;
      valid_q    <= '0;
      zero_q     <= '1;
      byp_q      <= '0;
      byp_data_q <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q   <= cnt_q + 1'b1;
          valid_q <= '0;
          if (cnt_q == LAST) begin
            state_q   <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NUM_RD; i++) begin
            valid_q[i] <= req[i];
            if (req[i]) begin
              zero_q[i]     <= !in_range[i];
              byp_q[i]      <= wr_ok && (wr_addr == raddr[i]);
              byp_data_q[i] <= wr_data;
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign rd_valid = valid_q[0];
  assign rd_data  = data[0];
`ifdef OPERAND_MEMORY_RD2_EN
  assign rd2_valid = valid_q[1];
  assign rd2_data  = data[1];
`endif

endmodule

// File: tb/tb_operand_memory.sv
// Bench for operand_memory: two instances (DEPTH 16 and DEPTH 12) share one
// randomized stimulus stream; a behavioural model predicts every output.
module tb_operand_memory;

  localparam logic [15:0] TABLE [16] = '{
    16'h4DA3, 16'h1F2C, 16'h83B7, 16'h5E01,
    16'h0A9D, 16'hD635, 16'h7C48, 16'h2B6E,
    16'h91F0, 16'h3D27, 16'hE4A2, 16'h6B59,
    16'hC08E, 16'h17D4, 16'hA36B, 16'hD919
  };
  localparam int D [2] = '{16, 12};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd2_en = 1'b0;
  logic [3:0]  rd2_addr = '0;

  logic        busy [2];
  logic        valid [2][2];
  logic [15:0] data [2][2];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  operand_memory #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u_a (
    .clk       (clk),
    .rst       (rst),
    .init_busy (busy[0]),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (valid[0][0]),
    .rd_data   (data[0][0])
`ifdef OPERAND_MEMORY_RD2_EN
    ,
    .rd2_en    (rd2_en),
    .rd2_addr  (rd2_addr),
    .rd2_valid (valid[0][1]),
    .rd2_data  (data[0][1])
`endif
  );

  operand_memory #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) u_b (
    .clk       (clk),
    .rst       (rst),
    .init_busy (busy[1]),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (valid[1][0]),
    .rd_data   (data[1][0])
`ifdef OPERAND_MEMORY_RD2_EN
    ,
    .rd2_en    (rd2_en),
    .rd2_addr  (rd2_addr),
    .rd2_valid (valid[1][1]),
    .rd2_data  (data[1][1])
`endif
  );

  // ---------------- behavioural model ----------------
  int          left [2];
  logic [15:0] mm [2][16];
  logic        ev [2][2];
  logic [15:0] ed [2][2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        left[k] = D[k];
        for (int p = 0; p < 2; p++) begin
          ev[k][p] = 1'b0;
          ed[k][p] = 16'h0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (left[k] > 0) begin
          left[k] = left[k] - 1;
          ev[k][0] = 1'b0;
          ev[k][1] = 1'b0;
          if (left[k] == 0)
            for (int i = 0; i < D[k]; i++) mm[k][i] = TABLE[i];
        end else begin
          for (int p = 0; p < 2; p++) begin
            logic       re;
            logic [3:0] ra;
            re = (p == 0) ? rd_en : rd2_en;
            ra = (p == 0) ? rd_addr : rd2_addr;
            ev[k][p] = re;
            if (re) begin
              if (int'(ra) >= D[k])                 ed[k][p] = 16'h0;
              else if (wr_en && wr_addr == ra)     ed[k][p] = wr_data;
              else                                 ed[k][p] = mm[k][ra];
            end
          end
          if (wr_en && int'(wr_addr) < D[k]) mm[k][wr_addr] = wr_data;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs are meaningful every cycle once reset was applied.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(left[k] > 0));
        check($sformatf("rd_valid[%0d]", k), 32'(valid[k][0]), 32'(ev[k][0]));
        check($sformatf("rd_data[%0d]", k), 32'(data[k][0]), 32'(ed[k][0]));
`ifdef OPERAND_MEMORY_RD2_EN
        check($sformatf("rd2_valid[%0d]", k), 32'(valid[k][1]), 32'(ev[k][1]));
        check($sformatf("rd2_data[%0d]", k), 32'(data[k][1]), 32'(ed[k][1]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic re2, input logic [3:0] ra2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
`ifdef OPERAND_MEMORY_RD2_EN
    rd2_en = re2; rd2_addr = ra2;
`else
    rd2_en = 1'b0; rd2_addr = ra2 & 4'h0 | (re2 ? 4'h0 : 4'h0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    wr_en = 1'($urandom % 2);
    wr_addr = 4'($urandom % 16);
    wr_data = 16'($urandom);
    rd_en = 1'($urandom % 3 != 0);
    rd_addr = ($urandom % 4 == 0) ? wr_addr : 4'($urandom % 16);
`ifdef OPERAND_MEMORY_RD2_EN
    rd2_en = 1'($urandom % 2);
    rd2_addr = ($urandom % 4 == 0) ? rd_addr : 4'($urandom % 16);
`endif
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    int ca = -1;
    int cb = -1;
    while ((ca < 0 || cb < 0) && cyc < 100) begin
      rand_inputs();
      @(posedge clk);
      #1;
      cyc++;
      if (ca < 0 && !busy[0]) ca = cyc;
      if (cb < 0 && !busy[1]) cb = cyc;
    end
    check({tag, "_init_cycles_d16"}, 32'(ca), 32'd16);
    check({tag, "_init_cycles_d12"}, 32'(cb), 32'd12);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_busy", 32'(busy[0]), 32'd1);
    check("reset_valid", 32'(valid[0][0]), 32'd0);
    check("reset_data", 32'(data[0][0]), 32'd0);
    rst = 1'b0;
    wait_init("first");

    // Default table and valid pulse
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0, 4'd0);
    check("rd_addr0", 32'(data[0][0]), 32'h4DA3);
    check("rd_valid_pulse", 32'(valid[0][0]), 32'd1);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0, 4'd0);
    check("rd_addr5", 32'(data[0][0]), 32'hD635);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 1'b0, 4'd0);
    check("rd_addr15", 32'(data[0][0]), 32'hD919);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("valid_drops", 32'(valid[0][0]), 32'd0);
    check("data_holds", 32'(data[0][0]), 32'hD919);

    // Write then read
    drive(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0);
    check("wr_rd_addr3", 32'(data[0][0]), 32'hBEEF);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd0);
    check("rd_addr4_default", 32'(data[0][0]), 32'h0A9D);

    // Write-first on same address
    drive(1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 1'b0, 4'd0);
    check("write_first", 32'(data[0][0]), 32'h1234);

    // Out of range on the DEPTH=12 instance
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd13, 1'b0, 4'd0);
    check("oor_rd_data", 32'(data[1][0]), 32'd0);
    check("oor_rd_valid", 32'(valid[1][0]), 32'd1);
    drive(1'b1, 4'd13, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd13, 1'b0, 4'd0);
    check("oor_write_dropped", 32'(data[1][0]), 32'd0);

`ifdef OPERAND_MEMORY_RD2_EN
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b1, 4'd2);
    check("dual_rd_port1", 32'(data[0][0]), 32'h83B7);
    check("dual_rd_port2", 32'(data[0][1]), 32'h83B7);
`endif

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end

    // Reset in the middle of back-to-back reads
    drive(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int n = 0; n < 4; n++) drive(1'b0, 4'd0, 16'h0, 1'b1, 4'(n + 2), 1'b1, 4'(n));
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(valid[0][0]), 32'd0);
    check("midrst_data", 32'(data[0][0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init("second");
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0);
    check("addr3_default_after_reinit", 32'(data[0][0]), 32'h5E01);

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
